// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: run state,
// load-value clamping and prescaler sizing.
package counter_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Prescaler counter width: $clog2(PRESCALE), never narrower than 1 bit.
  function automatic int presc_width(input int prescale);
    return ($clog2(prescale) < 1) ? 1 : $clog2(prescale);
  endfunction

  localparam int DEFAULT_PRESCALE    = 1;
  localparam int DEFAULT_PRESC_WIDTH = presc_width(DEFAULT_PRESCALE);

  // Load values outside the count sequence saturate to the terminal count.
  function automatic int clamp_to_mod(input int value, input int modulus);
    return (value >= modulus) ? (modulus - 1) : value;
  endfunction

endpackage

// File: rtl/clk_en_prescaler.sv
// Clock-enable prescaler: emits a one-cycle step every PRESCALE enabled
// clocks. Holds its phase while en is low; clr restarts the phase.
module clk_en_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int              PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_reg;

  assign step = en && (cnt_reg == LAST);

  // Phase counter: advances on enabled clocks, wraps on the step cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (cnt_reg == LAST) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_up_counter.sv
// Modulo-MOD up counter with parallel load, prescaled enable and
// free-run / one-shot modes. tc and wrap allow cascading.
module sync_up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             en,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             ovf
);

  // Terminal value compared explicitly so MOD < 2^WIDTH works and the
  // increment never depends on natural overflow.
  localparam logic [WIDTH-1:0] TERM = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_reg;
  logic             wrap_reg;
  logic             done_reg;
  logic             ovf_reg;
  state_t           state_reg;
  logic             step;
  logic [WIDTH-1:0] d_clamped;

  assign d_clamped = WIDTH'(clamp_to_mod(int'(d), MOD));

  // Both set and load restart the prescale phase.
  clk_en_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (set | load),
    .en    (en),
    .step  (step)
  );

  assign o    = count_reg;
  assign wrap = wrap_reg;
  assign done = done_reg;
  assign ovf  = ovf_reg;
  assign tc   = (count_reg == TERM) && step && (state_reg == RUN);

  // Count/state update with priority set > load > step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      state_reg <= RUN;
    end else if (set) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      state_reg <= RUN;
    end else if (load) begin
      count_reg <= d_clamped;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
      state_reg <= RUN;
    end else begin
      wrap_reg <= 1'b0;
      if (state_reg == RUN && step) begin
        if (count_reg == TERM) begin
          if (oneshot) begin
            state_reg <= HOLD;
            done_reg  <= 1'b1;
          end else begin
            count_reg <= '0;
            wrap_reg  <= 1'b1;
            ovf_reg   <= 1'b1;
          end
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_up_counter.sv
// Directed bench for sync_up_counter: three instances (MOD 16, MOD 10,
// PRESCALE 3) share one stimulus set; each scenario checks one of them.
module tb_sync_up_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set = 1'b0;
  logic       en = 1'b0;
  logic       oneshot = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d = 4'h0;

  logic [3:0] o16, o10, o3;
  logic       tc16, tc10, tc3;
  logic       wrap16, wrap10, wrap3;
  logic       done16, done10, done3;
  logic       ovf16, ovf10, ovf3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_up_counter #(.WIDTH(4), .MOD(16), .PRESCALE(1)) u16 (
    .clk(clk), .rst_n(rst_n), .set(set), .en(en), .oneshot(oneshot),
    .load(load), .d(d), .o(o16), .tc(tc16), .wrap(wrap16), .done(done16), .ovf(ovf16));

  sync_up_counter #(.WIDTH(4), .MOD(10), .PRESCALE(1)) u10 (
    .clk(clk), .rst_n(rst_n), .set(set), .en(en), .oneshot(oneshot),
    .load(load), .d(d), .o(o10), .tc(tc10), .wrap(wrap10), .done(done10), .ovf(ovf10));

  sync_up_counter #(.WIDTH(4), .MOD(16), .PRESCALE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .set(set), .en(en), .oneshot(oneshot),
    .load(load), .d(d), .o(o3), .tc(tc3), .wrap(wrap3), .done(done3), .ovf(ovf3));

  // Synchronous clear of all instances; leaves en at en_after.
  task automatic pulse_set(input logic en_after);
    @(negedge clk);
    set = 1'b1; load = 1'b0; en = 1'b0;
    @(negedge clk);
    set = 1'b0; en = en_after;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; set = 1'b0; en = 1'b0; load = 1'b0; oneshot = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o16, wrap16, done16, ovf16} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_state: o=%0d wrap=%b done=%b ovf=%b, required all 0", o16, wrap16, done16, ovf16);
    end
    $display("reset: o=%0d wrap=%b done=%b ovf=%b", o16, wrap16, done16, ovf16);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run;
    @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      $display("free_run step %0d: o=%0d tc=%b wrap=%b ovf=%b", i, o16, tc16, wrap16, ovf16);
      n_cmp++;
      if (o16 !== 4'(i % 16)) begin
        n_bad++;
        $display("FAIL free_run_o: step %0d o=%0d, required %0d", i, o16, i % 16);
      end
      n_cmp++;
      if (wrap16 !== (i == 16)) begin
        n_bad++;
        $display("FAIL free_run_wrap: step %0d wrap=%b, required %b", i, wrap16, (i == 16));
      end
      n_cmp++;
      if (ovf16 !== (i >= 16)) begin
        n_bad++;
        $display("FAIL free_run_ovf: step %0d ovf=%b, required %b", i, ovf16, (i >= 16));
      end
      n_cmp++;
      if (tc16 !== (i == 15)) begin
        n_bad++;
        $display("FAIL free_run_tc: step %0d tc=%b, required %b", i, tc16, (i == 15));
      end
    end
  endtask

  task automatic test_modulus;
    int wraps;
    pulse_set(1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      $display("modulus step %0d: o=%0d tc=%b wrap=%b", i, o10, tc10, wrap10);
      n_cmp++;
      if (o10 !== 4'(i % 10)) begin
        n_bad++;
        $display("FAIL mod10_o: step %0d o=%0d, required %0d", i, o10, i % 10);
      end
      n_cmp++;
      if (tc10 !== (i % 10 == 9)) begin
        n_bad++;
        $display("FAIL mod10_tc: step %0d tc=%b, required %b", i, tc10, (i % 10 == 9));
      end
    end
    // 150 ns at a 10 ns clock: 15 steps from 0.
    pulse_set(1'b1);
    wraps = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (wrap10) wraps++;
    end
    $display("modulus 150ns run: o=%0d wraps=%0d", o10, wraps);
    n_cmp++;
    if (o10 !== 4'd5 || wraps != 1) begin
      n_bad++;
      $display("FAIL mod10_150ns: o=%0d wraps=%0d, required o=5 wraps=1", o10, wraps);
    end
  endtask

  task automatic test_oneshot;
    oneshot = 1'b1;
    pulse_set(1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      $display("oneshot step %0d: o=%0d done=%b wrap=%b", i, o16, done16, wrap16);
      n_cmp++;
      if (o16 !== 4'((i > 15) ? 15 : i)) begin
        n_bad++;
        $display("FAIL oneshot_o: step %0d o=%0d, required %0d", i, o16, (i > 15) ? 15 : i);
      end
      n_cmp++;
      if (done16 !== (i >= 16)) begin
        n_bad++;
        $display("FAIL oneshot_done: step %0d done=%b, required %b", i, done16, (i >= 16));
      end
      n_cmp++;
      if (wrap16 !== 1'b0) begin
        n_bad++;
        $display("FAIL oneshot_wrap: step %0d wrap=%b, required 0", i, wrap16);
      end
    end
    @(negedge clk);
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
    $display("oneshot after set: o=%0d done=%b", o16, done16);
    n_cmp++;
    if (o16 !== 4'd0 || done16 !== 1'b0) begin
      n_bad++;
      $display("FAIL oneshot_set: o=%0d done=%b, required o=0 done=0", o16, done16);
    end
    @(negedge clk);
    $display("oneshot resume: o=%0d", o16);
    n_cmp++;
    if (o16 !== 4'd1) begin
      n_bad++;
      $display("FAIL oneshot_resume: o=%0d, required 1", o16);
    end
    oneshot = 1'b0;
  endtask

  task automatic test_load_priority;
    pulse_set(1'b1);
    repeat (3) @(negedge clk);
    load = 1'b1; d = 4'hC;
    @(negedge clk);
    load = 1'b0;
    $display("load C: o=%0d", o16);
    n_cmp++;
    if (o16 !== 4'd12) begin
      n_bad++;
      $display("FAIL load_value: o=%0d, required 12", o16);
    end
    @(negedge clk);
    n_cmp++;
    if (o16 !== 4'd13) begin
      n_bad++;
      $display("FAIL load_then_count: o=%0d, required 13", o16);
    end
    load = 1'b1; set = 1'b1; d = 4'h5;
    @(negedge clk);
    load = 1'b0; set = 1'b0;
    $display("load+set: o=%0d", o16);
    n_cmp++;
    if (o16 !== 4'd0) begin
      n_bad++;
      $display("FAIL set_over_load: o=%0d, required 0", o16);
    end
    en = 1'b0; load = 1'b1; d = 4'hF;
    @(negedge clk);
    load = 1'b0;
    $display("load F: o16=%0d o10=%0d", o16, o10);
    n_cmp++;
    if (o10 !== 4'd9 || o16 !== 4'd15) begin
      n_bad++;
      $display("FAIL load_clamp: o10=%0d o16=%0d, required o10=9 o16=15", o10, o16);
    end
  endtask

  task automatic test_prescale;
    logic [3:0] exp_o [7];
    exp_o = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
    pulse_set(1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      $display("prescale edge %0d: o=%0d", i + 1, o3);
      n_cmp++;
      if (o3 !== exp_o[i]) begin
        n_bad++;
        $display("FAIL prescale_o: edge %0d o=%0d, required %0d", i + 1, o3, exp_o[i]);
      end
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (o3 !== 4'd2) begin
      n_bad++;
      $display("FAIL prescale_freeze: o=%0d, required 2", o3);
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o3 !== 4'd2) begin
      n_bad++;
      $display("FAIL prescale_phase_a: o=%0d, required 2", o3);
    end
    @(negedge clk);
    $display("prescale resumed: o=%0d", o3);
    n_cmp++;
    if (o3 !== 4'd3) begin
      n_bad++;
      $display("FAIL prescale_phase_b: o=%0d, required 3", o3);
    end
  endtask

  task automatic test_async_reset;
    pulse_set(1'b1);
    repeat (23) @(negedge clk);
    $display("pre-reset: o=%0d ovf=%b", o16, ovf16);
    n_cmp++;
    if (o16 !== 4'd7 || ovf16 !== 1'b1) begin
      n_bad++;
      $display("FAIL async_setup: o=%0d ovf=%b, required o=7 ovf=1", o16, ovf16);
    end
    #2 rst_n = 1'b0;
    #1;
    $display("mid-cycle reset: o=%0d ovf=%b", o16, ovf16);
    n_cmp++;
    if (o16 !== 4'd0 || ovf16 !== 1'b0) begin
      n_bad++;
      $display("FAIL async_clear: o=%0d ovf=%b, required o=0 ovf=0", o16, ovf16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o16 !== 4'd1) begin
      n_bad++;
      $display("FAIL async_first_step: o=%0d, required 1", o16);
    end
    n_cmp++;
    if (o3 !== 4'd0) begin
      n_bad++;
      $display("FAIL async_presc_edge1: o3=%0d, required 0", o3);
    end
    repeat (2) @(negedge clk);
    $display("after reset: o16=%0d o3=%0d", o16, o3);
    n_cmp++;
    if (o3 !== 4'd1) begin
      n_bad++;
      $display("FAIL async_presc_discard: o3=%0d, required 1", o3);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_modulus();
    test_oneshot();
    test_load_priority();
    test_prescale();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_up_counter.md
Name: sync_up_counter

Overview:
- Synchronous 4-bit (parameterizable) up counter, the count-up counterpart to the team's down counter.
- Supports a programmable modulus, parallel load, count enable and a clock-enable prescaler.
- Offers free-run (wrap) and one-shot (stop at terminal) modes.
- Used as the event/tick source for timing blocks; outputs `tc` and `wrap` let counters be cascaded.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 16, modulus; count sequence is 0..MOD-1; legal range 2..2^WIDTH.
- PRESCALE, 1, input clocks per count step; 1 means a step on every enabled clock; legal range 1..256.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- set  in  1  synchronous clear: count to 0, state to RUN, prescaler to 0.
- en  in  1  count enable.
- oneshot  in  1  mode: 0 = free-run wrap, 1 = stop at MOD-1.
- load  in  1  synchronous parallel load.
- d  in  WIDTH  load value; values >= MOD load as MOD-1.
- o  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational: o==MOD-1 && step && state==RUN.
- wrap  out  1  registered one-cycle pulse, high the cycle after o goes from MOD-1 to 0.
- done  out  1  registered; high while state==HOLD.
- ovf  out  1  sticky; set on any wrap, cleared only by set or reset.

Behaviour:
- Clock and reset
  - One clock domain.
  - rst_n is asynchronous, active-low. While low: o=0, wrap=0, done=0, ovf=0, prescaler=0, state=RUN.
  - Deassertion is synchronised externally; the block has no reset synchroniser.
- Priority at each rising edge: rst_n low > set > load > step.
- step (internal)
  - step = en && (prescale_cnt == PRESCALE-1).
  - The prescaler advances only when en=1, wraps to 0 on step, and holds when en=0.
  - With PRESCALE=1, step = en.
- States: RUN, HOLD.
  - RUN, step, o<MOD-1: o <= o+1.
  - RUN, step, o==MOD-1, oneshot=0: o <= 0, wrap <= 1, ovf <= 1.
  - RUN, step, o==MOD-1, oneshot=1: o holds at MOD-1, state <= HOLD, done <= 1. No wrap, no ovf.
  - HOLD: o holds and en is ignored. Exit only via set (to RUN, o=0) or load (to RUN, o=d clamped).
- load: o <= clamp(d), prescaler <= 0, wrap <= 0. It takes priority over a coincident step; no increment happens that cycle.
- set: o <= 0, ovf <= 0, done <= 0, wrap <= 0. Overrides a coincident load and step.
- wrap defaults to 0 every cycle it is not set.
- Latency: o updates on the same edge as a qualifying step (1 cycle from en sampled high).
- Width rules: the increment is WIDTH bits and never relies on natural overflow. Comparison is against MOD-1 so that MOD < 2^WIDTH works.
- Changing oneshot mid-count takes effect at the next terminal step.
- An async reset mid-prescale discards the partial prescale count.

Decomposition:
- Shared package `counter_pkg`:
  - state typedef (RUN, HOLD);
  - function clamp_to_mod;
  - localparam for the prescaler width, $clog2(PRESCALE) with a minimum of 1.
- One sub-module, `clk_en_prescaler`:
  - inputs clk, rst_n, clr, en; output step;
  - reusable by the down counter.

Test Plan:
- Reset and free-run: rst_n=0 for 10 ns, then set=0, en=1, oneshot=0, MOD=16, PRESCALE=1.
  - Required: o=0,1,…,15,0 on consecutive edges.
  - wrap high for exactly 1 cycle after 15→0; ovf stays 1.
- Modulus: MOD=10, en=1.
  - Required: o cycles 0..9 then 0.
  - tc high only in the cycle with o=9.
  - 150 ns run at a 10 ns clock gives 1 wrap; o=5 at the end.
- One-shot: oneshot=1, MOD=16, en=1.
  - Required: o stops at 15 and done=1 from the next edge; wrap never pulses.
  - A set pulse afterwards gives o=0, done=0 and counting resumes.
- Load and priority:
  - load=1, d=4'hC, en=1 in the same cycle → o=12, no increment that cycle.
  - load=1 and set=1 together → o=0.
  - d=4'hF with MOD=10 → o=9.
- Prescale and enable: PRESCALE=3, en=1.
  - Required: o increments every 3rd edge.
  - Dropping en for 2 cycles mid-prescale freezes o and the prescaler; counting resumes with the same phase.
- Async reset mid-operation: assert rst_n low between clock edges with o=7 and ovf=1.
  - Required: o=0 and ovf=0 immediately, without waiting for a clock edge.
  - After release, the first step gives o=1.
